// File: rtl/led_pattern_ctrl_if.sv
// LED bank bus: raw button in, LED drive and current mode out.
// The master side (board top / bench) drives the button; the slave side
// (the sequencer) drives the LEDs and reports the active mode.
interface led_pattern_ctrl_if;
    logic       btn;
    logic [7:0] LED;
    logic [1:0] mode;

    modport master (
        output btn,
        input  LED,
        input  mode
    );

    modport slave (
        input  btn,
        output LED,
        output mode
    );
endinterface

// File: rtl/led_pattern_ctrl.sv
// LED pattern sequencer: synchronises and debounces one push button, steps
// through OFF / COUNT / SCAN / BLINK on each accepted press, and animates the
// selected pattern from an internal step prescaler. LED and mode are flops.
module led_pattern_ctrl #(
    parameter int unsigned STEP_DIV = 6_250_000,
    parameter int unsigned DEBOUNCE = 500_000
) (
    input  logic                clk,
    input  logic                rst,
    led_pattern_ctrl_if.slave   bus
);

    localparam int unsigned PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [PW-1:0] P_MAX = PW'(STEP_DIV - 1);
    localparam logic [DW-1:0] D_MAX = DW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_COUNT = 2'd1,
        MODE_SCAN  = 2'd2,
        MODE_BLINK = 2'd3
    } mode_e;

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          deb_q, deb_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    mode_e         mode_q, mode_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [2:0]    pos_q, pos_d;
    logic          dir_q, dir_d;      // 0 = moving up, 1 = moving down
    logic          phase_q, phase_d;
    logic [7:0]    led_q, led_d;

    logic          press_s;
    logic          tick_s;
    logic [1:0]    mode_inc_s;
    logic [2:0]    pos_up_s;
    logic [2:0]    pos_dn_s;
    logic [7:0]    cnt_inc_s;

    // Next-state logic: button path, prescaler and pattern stepping.
    always_comb begin
        s1_d       = bus.btn;
        s2_d       = s1_q;
        deb_d      = deb_q;
        dcnt_d     = dcnt_q;
        pcnt_d     = pcnt_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        pos_d      = pos_q;
        dir_d      = dir_q;
        phase_d    = phase_q;
        led_d      = led_q;
        press_s    = 1'b0;
        tick_s     = (pcnt_q == P_MAX);
        mode_inc_s = mode_q + 2'd1;
        pos_up_s   = pos_q + 3'd1;
        pos_dn_s   = pos_q - 3'd1;
        cnt_inc_s  = cnt_q + 8'd1;

        // Debouncer: a level change is accepted only after it has been
        // stable for DEBOUNCE consecutive cycles; any agreement restarts it.
        if (s2_q == deb_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == D_MAX) begin
            deb_d   = s2_q;
            dcnt_d  = '0;
            press_s = s2_q;
        end else begin
            dcnt_d = dcnt_q + 1'b1;
        end

        // A press outranks a coincident tick: the step is dropped and all
        // pattern state restarts for the newly selected mode.
        if (press_s) begin
            mode_d  = mode_e'(mode_inc_s);
            pcnt_d  = '0;
            cnt_d   = 8'd0;
            pos_d   = 3'd0;
            dir_d   = 1'b0;
            phase_d = 1'b0;
            case (mode_e'(mode_inc_s))
                MODE_SCAN: led_d = 8'h01;
                default:   led_d = 8'h00;
            endcase
        end else if (tick_s) begin
            pcnt_d = '0;
            case (mode_q)
                MODE_COUNT: begin
                    cnt_d = cnt_inc_s;
                    led_d = cnt_inc_s;
                end
                MODE_SCAN: begin
                    if (!dir_q) begin
                        pos_d = pos_up_s;
                        led_d = 8'h01 << pos_up_s;
                        if (pos_up_s == 3'd7) begin
                            dir_d = 1'b1;
                        end else begin
                            dir_d = 1'b0;
                        end
                    end else begin
                        pos_d = pos_dn_s;
                        led_d = 8'h01 << pos_dn_s;
                        if (pos_dn_s == 3'd0) begin
                            dir_d = 1'b0;
                        end else begin
                            dir_d = 1'b1;
                        end
                    end
                end
                MODE_BLINK: begin
                    phase_d = ~phase_q;
                    led_d   = (~phase_q) ? 8'hFF : 8'h00;
                end
                default: begin
                    led_d = 8'h00;
                end
            endcase
        end else begin
            pcnt_d = pcnt_q + 1'b1;
        end
    end

    // State registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            deb_q   <= 1'b0;
            dcnt_q  <= '0;
            pcnt_q  <= '0;
            mode_q  <= MODE_OFF;
            cnt_q   <= 8'd0;
            pos_q   <= 3'd0;
            dir_q   <= 1'b0;
            phase_q <= 1'b0;
            led_q   <= 8'h00;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            deb_q   <= deb_d;
            dcnt_q  <= dcnt_d;
            pcnt_q  <= pcnt_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            phase_q <= phase_d;
            led_q   <= led_d;
        end
    end

    assign bus.LED  = led_q;
    assign bus.mode = mode_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with STEP_DIV=4, DEBOUNCE=3.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_led_pattern_ctrl;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    led_pattern_ctrl_if bus_if ();

    led_pattern_ctrl #(
        .STEP_DIV (4),
        .DEBOUNCE (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance n rising edges, land 1 ns after the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // raise button, hold until the press edge, then release
    task automatic do_press();
        bus_if.btn = 1'b1;
        step(5);
        bus_if.btn = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.btn = 1'b0;
        step(2);
        n_cmp++; if (bus_if.LED !== 8'h00) begin n_bad++; $display("FAIL reset_led: got %h expected 00", bus_if.LED); end
        n_cmp++; if (bus_if.mode !== 2'd0) begin n_bad++; $display("FAIL reset_mode: got %0d expected 0", bus_if.mode); end
        rst = 1'b0;
        step(4);
        n_cmp++; if (bus_if.LED !== 8'h00) begin n_bad++; $display("FAIL off_tick_led: got %h expected 00", bus_if.LED); end
    endtask

    task automatic test_press();
        bus_if.btn = 1'b1;
        step(4);
        n_cmp++; if (bus_if.mode !== 2'd0) begin n_bad++; $display("FAIL press_early: got %0d expected 0", bus_if.mode); end
        step(1);
        n_cmp++; if (bus_if.mode !== 2'd1) begin n_bad++; $display("FAIL press_mode: got %0d expected 1", bus_if.mode); end
        n_cmp++; if (bus_if.LED !== 8'h00) begin n_bad++; $display("FAIL press_led: got %h expected 00", bus_if.LED); end
        bus_if.btn = 1'b0;
        step(3);
        n_cmp++; if (bus_if.LED !== 8'h00) begin n_bad++; $display("FAIL count_pre: got %h expected 00", bus_if.LED); end
        for (int j = 1; j <= 3; j++) begin
            step((j == 1) ? 1 : 4);
            n_cmp++; if (bus_if.LED !== 8'(j)) begin n_bad++; $display("FAIL count_step%0d: got %h expected %h", j, bus_if.LED, 8'(j)); end
        end
        step(4 * 252);
        n_cmp++; if (bus_if.LED !== 8'hFF) begin n_bad++; $display("FAIL count_ff: got %h expected ff", bus_if.LED); end
        step(4);
        n_cmp++; if (bus_if.LED !== 8'h00) begin n_bad++; $display("FAIL count_wrap: got %h expected 00", bus_if.LED); end
        n_cmp++; if (bus_if.mode !== 2'd1) begin n_bad++; $display("FAIL count_mode_hold: got %0d expected 1", bus_if.mode); end
    endtask

    task automatic test_glitch();
        bus_if.btn = 1'b1;
        step(2);
        bus_if.btn = 1'b0;
        step(6);
        n_cmp++; if (dut.dcnt_q !== 2'd0) begin n_bad++; $display("FAIL glitch_dcnt: got %0d expected 0", dut.dcnt_q); end
        n_cmp++; if (bus_if.mode !== 2'd1) begin n_bad++; $display("FAIL glitch_mode: got %0d expected 1", bus_if.mode); end
        for (int i = 0; i < 17; i++) begin
            bus_if.btn = 1'b1;
            step(2);
            bus_if.btn = 1'b0;
            step(1);
        end
        step(6);
        n_cmp++; if (bus_if.mode !== 2'd1) begin n_bad++; $display("FAIL chatter_mode: got %0d expected 1", bus_if.mode); end
    endtask

    task automatic test_scan();
        logic [7:0] scan_exp [16];
        scan_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                     8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
        do_press();
        n_cmp++; if (bus_if.mode !== 2'd2) begin n_bad++; $display("FAIL scan_mode: got %0d expected 2", bus_if.mode); end
        n_cmp++; if (bus_if.LED !== 8'h01) begin n_bad++; $display("FAIL scan_init: got %h expected 01", bus_if.LED); end
        for (int i = 0; i < 16; i++) begin
            step(4);
            n_cmp++; if (bus_if.LED !== scan_exp[i]) begin n_bad++; $display("FAIL scan_step%0d: got %h expected %h", i, bus_if.LED, scan_exp[i]); end
            n_cmp++; if ($countones(bus_if.LED) != 1) begin n_bad++; $display("FAIL scan_onehot%0d: got %0d bits expected 1", i, $countones(bus_if.LED)); end
        end
    endtask

    task automatic test_blink();
        step(2);
        bus_if.btn = 1'b1;
        step(5);
        n_cmp++; if (bus_if.mode !== 2'd3) begin n_bad++; $display("FAIL blink_mode: got %0d expected 3", bus_if.mode); end
        n_cmp++; if (bus_if.LED !== 8'h00) begin n_bad++; $display("FAIL blink_init: got %h expected 00", bus_if.LED); end
        bus_if.btn = 1'b0;      // two-cycle release bounce
        step(2);
        bus_if.btn = 1'b1;
        step(2);
        n_cmp++; if (bus_if.LED !== 8'hFF) begin n_bad++; $display("FAIL blink_t1: got %h expected ff", bus_if.LED); end
        bus_if.btn = 1'b0;
        step(4);
        n_cmp++; if (bus_if.LED !== 8'h00) begin n_bad++; $display("FAIL blink_t2: got %h expected 00", bus_if.LED); end
        step(4);
        n_cmp++; if (bus_if.LED !== 8'hFF) begin n_bad++; $display("FAIL blink_t3: got %h expected ff", bus_if.LED); end
        n_cmp++; if (bus_if.mode !== 2'd3) begin n_bad++; $display("FAIL release_bounce: got %0d expected 3", bus_if.mode); end
    endtask

    task automatic test_wrap();
        step(2);
        do_press();
        n_cmp++; if (bus_if.mode !== 2'd0) begin n_bad++; $display("FAIL wrap_mode: got %0d expected 0", bus_if.mode); end
        n_cmp++; if (bus_if.LED !== 8'h00) begin n_bad++; $display("FAIL wrap_led: got %h expected 00", bus_if.LED); end
        step(4);
        n_cmp++; if (bus_if.LED !== 8'h00) begin n_bad++; $display("FAIL wrap_tick: got %h expected 00", bus_if.LED); end
        step(2);
    endtask

    task automatic test_collision();
        do_press();
        n_cmp++; if (bus_if.mode !== 2'd1) begin n_bad++; $display("FAIL coll_enter: got %0d expected 1", bus_if.mode); end
        step(16);
        n_cmp++; if (bus_if.LED !== 8'h04) begin n_bad++; $display("FAIL coll_cnt4: got %h expected 04", bus_if.LED); end
        step(3);
        bus_if.btn = 1'b1;
        step(1);
        n_cmp++; if (bus_if.LED !== 8'h05) begin n_bad++; $display("FAIL coll_cnt5: got %h expected 05", bus_if.LED); end
        step(4);
        n_cmp++; if (bus_if.mode !== 2'd2) begin n_bad++; $display("FAIL coll_mode: got %0d expected 2", bus_if.mode); end
        n_cmp++; if (bus_if.LED !== 8'h01) begin n_bad++; $display("FAIL coll_led: got %h expected 01", bus_if.LED); end
        bus_if.btn = 1'b0;
        step(3);
        n_cmp++; if (bus_if.LED !== 8'h01) begin n_bad++; $display("FAIL coll_hold: got %h expected 01", bus_if.LED); end
        step(1);
        n_cmp++; if (bus_if.LED !== 8'h02) begin n_bad++; $display("FAIL coll_next: got %h expected 02", bus_if.LED); end
    endtask

    task automatic test_reset_mid();
        step(2);
        rst = 1'b1;
        step(1);
        n_cmp++; if (bus_if.LED !== 8'h00) begin n_bad++; $display("FAIL midrst_led: got %h expected 00", bus_if.LED); end
        n_cmp++; if (bus_if.mode !== 2'd0) begin n_bad++; $display("FAIL midrst_mode: got %0d expected 0", bus_if.mode); end
        step(1);
        rst = 1'b0;
        step(4);
        n_cmp++; if (bus_if.LED !== 8'h00) begin n_bad++; $display("FAIL midrst_tick: got %h expected 00", bus_if.LED); end
        n_cmp++; if (bus_if.mode !== 2'd0) begin n_bad++; $display("FAIL midrst_mode_hold: got %0d expected 0", bus_if.mode); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus_if.btn = 1'b0;
        test_reset();
        test_press();
        test_glitch();
        test_scan();
        test_blink();
        test_wrap();
        test_collision();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Sequencer for the 8-LED bank on the board. It takes one raw push-button input, synchronises and debounces it, and uses each accepted press to step through four display modes. Each mode drives its own LED pattern, advanced by an internal step prescaler. It replaces the free-running counter-to-LED connection at the top level and is the only block that drives `LED[7:0]`.

## Interface
Parameters:
- `STEP_DIV`, default 6_250_000: clocks per pattern step (8 steps/s at 50 MHz); legal range ≥ 2.
- `DEBOUNCE`, default 500_000: consecutive stable clocks needed to accept a button level change (10 ms at 50 MHz); legal range ≥ 1.

Ports:
- `clk`  input  1  50 MHz system clock; one clock domain only.
- `rst`  input  1  synchronous, active-high reset.
- `btn`  input  1  raw, asynchronous, active-high push button.
- `LED`  output 8  registered LED drive, 1 = lit.
- `mode` output 2  current mode, registered.

## Operation
- **Button path**
  - 2-flop synchroniser: `btn` → `s1` → `s2`.
  - Debounced level `deb`, with counter `dcnt`.
  - If `s2 == deb`: `dcnt` is cleared to 0.
  - Otherwise `dcnt` increments. When `dcnt == DEBOUNCE-1` and `s2 != deb` still holds: `deb <= s2` and `dcnt <= 0`.
  - Accepted press = the `deb` 0→1 update. At that same edge, `mode <= mode + 1` (wraps 3→0).
  - Release (`deb` 1→0) is debounced the same way and has no other effect.
- **Step prescaler**
  - `pcnt` counts 0..STEP_DIV-1 and wraps.
  - `tick` is true when `pcnt == STEP_DIV-1`.
- **Modes**, all states updated on a `tick` edge:
  - 0 OFF: `LED = 8'h00`. Ticks are ignored.
  - 1 COUNT: 8-bit `cnt` increments; `LED = cnt`; wraps FF→00.
  - 2 SCAN: one lit bit, `LED = 1 << pos`. Bounce sequence is pos 0,1,…,7,6,…,1,0,1,… with no repeated endpoint.
    - Direction flips when pos reaches 7 (going up) or 0 (going down).
  - 3 BLINK: `phase` toggles; `LED = phase ? 8'hFF : 8'h00`.
- **Mode change.** On the press edge, the following all happen:
  - `pcnt <= 0`, `cnt <= 0`, `pos <= 0`, `dir <= up`, `phase <= 0`.
  - `LED` is loaded with the new mode's initial pattern: OFF 00, COUNT 00, SCAN 01, BLINK 00.
- **Simultaneous press and tick:** the mode change wins. The tick is discarded and its pattern step is not applied.
- **Reset values** (any time, including mid-debounce or mid-step):
  - `mode = 0`, `LED = 8'h00`.
  - `s1 = s2 = deb = 0`, `dcnt = 0`, `pcnt = 0`.
  - `cnt = 0`, `pos = 0`, `dir = up`, `phase = 0`.
  - `rst` has priority over all other activity.
- **Widths:**
  - `pcnt` and `dcnt` are sized by `$clog2` of their parameter.
  - `cnt` is 8 bits; `pos` is 3 bits.
  - No arithmetic overflow is possible beyond the stated wraps.

## Timing
- **Button latency.** Let edge k be the first edge at which `s1` samples `btn` high, with `btn` held high.
  - `deb` and `mode` update at edge k+1+DEBOUNCE.
  - The new mode's initial pattern appears on `LED` at that same edge.
- **Glitch rejection.** A high pulse on `btn` is ignored if `s2` stays high for fewer than DEBOUNCE consecutive cycles; `dcnt` then returns to 0.
- **Step timing.**
  - After reset, or after a mode change at edge m, the first pattern step occurs at edge m+STEP_DIV.
  - Subsequent steps occur every STEP_DIV edges.
- **Output registering.** `LED` and `mode` are registered. `LED` updates at the tick edge itself, with no extra pipeline cycle.
- **Pattern-state retention.** Pattern state of an inactive mode is not retained; re-entering a mode restarts its pattern.

## Test plan
All scenarios use `STEP_DIV=4`, `DEBOUNCE=3` unless stated.
- **Reset:** assert `rst` 2 cycles mid-operation in mode 2 → next edge `LED=00`, `mode=0`; first tick 4 edges after `rst` low leaves `LED=00`.
- **Press:** raise `btn` before edge k and hold → `mode` goes 0→1 at edge k+4 with `LED=00`. `LED` then reads 01, 02, 03 at edges k+8, k+12, k+16. After 256 steps `LED` wraps to 00.
- **Glitch:** `btn` high for 2 cycles → `mode` unchanged, `dcnt` back to 0. Repeated 2-on/1-off chatter for 50 cycles → no mode change.
- **Scan:** enter mode 2 → `LED` sequence 01,02,04,…,80,40,…,01,02 over 16 ticks, with exactly one bit set at every step.
- **Blink and wrap:** mode 3 gives 00,FF,00,FF on successive ticks. A 4th accepted press returns to mode 0 with `LED=00`. A release bounce of 2 cycles causes no extra advance.
- **Collision:** align the press edge with `pcnt==3` in mode 1 (`cnt=5`) → `mode=2`, `LED=01`, and the count step is not applied. The next step follows 4 edges later with `LED=02`.
